// File: rtl/modn_pkg.sv
// Shared definitions for the modulo-N counter family: width limit,
// a constant-evaluable ceil(log2) helper and the count direction encoding.
package modn_pkg;

  // Widest counter the family supports.
  localparam int MODN_MAX_WIDTH = 16;

  // Count direction as presented on the up input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int unsigned value);
    int          bits;
    int unsigned rem;
    bits = 0;
    rem  = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/modn_next.sv
// Next-state logic for modn_counter: resolves clear/load/count priority,
// clamps out-of-range loads and detects wrap in either direction.
// Arithmetic is carried one bit wider than the count so that the wrap
// detection also covers MODULUS == 2**WIDTH (plain binary overflow).
module modn_next
  import modn_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic [WIDTH-1:0] y,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y_nxt,
  output logic             wrap_evt,
  output logic             wrap_clr,
  output logic             tc
);

  // Modulus and last legal count, held at WIDTH+1 bits so 2**WIDTH fits.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST  = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] y_ext;
  logic [WIDTH:0] up_step;
  logic [WIDTH:0] dn_step;
  logic           at_top;
  logic           at_zero;
  logic           is_up;
  logic [WIDTH-1:0] ld_val;
  dir_t           dir;

  assign dir     = dir_t'(up);
  assign is_up   = (dir == DIR_UP);
  assign y_ext   = {1'b0, y};
  assign up_step = y_ext + 1'b1;
  assign dn_step = y_ext - 1'b1;
  // Stepping up lands exactly on MODULUS only from the last count;
  // stepping down borrows into the extra bit only from zero.
  assign at_top  = (up_step == MOD_W);
  assign at_zero = dn_step[WIDTH];
  // Loads at or beyond the modulus saturate to the last legal count.
  assign ld_val  = ({1'b0, d} < MOD_W) ? d : LAST[WIDTH-1:0];

  // Priority: clear > load > count > hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    y_nxt    = y;
    wrap_evt = 1'b0;
    wrap_clr = 1'b0;
    if (sclr) begin
      y_nxt    = '0;
      wrap_clr = 1'b1;
    end else if (ld) begin
      y_nxt    = ld_val;
      wrap_clr = 1'b1;
    end else if (en) begin
      if (is_up) begin
        if (at_top) begin
          y_nxt    = '0;
          wrap_evt = 1'b1;
        end else begin
          y_nxt = up_step[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          y_nxt    = LAST[WIDTH-1:0];
          wrap_evt = 1'b1;
        end else begin
          y_nxt = dn_step[WIDTH-1:0];
        end
      end
    end
  end

  // Terminal count: high in the cycle whose edge will wrap, so it can
  // serve directly as the enable of a following stage.
  assign tc = en & ~sclr & ~ld & ((is_up & at_top) | (~is_up & at_zero));

endmodule

// File: rtl/modn_counter.sv
// Parametrised synchronous modulo-N counter with enable, up/down,
// clamped parallel load, synchronous clear, terminal count and a
// sticky wrap flag. Only the count and flag registers live here.
module modn_counter
  import modn_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             sclr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             wrap
);

  // Reject configurations whose range cannot be represented.
  if (WIDTH < 1 || WIDTH > MODN_MAX_WIDTH || MODULUS < 2 ||
      clog2(MODULUS) > WIDTH) begin : g_bad_params
    $error("modn_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  logic [WIDTH-1:0] y_nxt;
  logic             wrap_evt;
  logic             wrap_clr;
  logic             tc_raw;

  modn_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .y        (y),
    .en       (en),
    .up       (up),
    .ld       (ld),
    .sclr     (sclr),
    .d        (d),
    .y_nxt    (y_nxt),
    .wrap_evt (wrap_evt),
    .wrap_clr (wrap_clr),
    .tc       (tc_raw)
  );

  // Count and sticky wrap registers, cleared asynchronously by rn.
  always_ff @(posedge clk or negedge rn) begin
    // NOTE: both state registers are small flops, so each gets an explicit
    // reset value; non-blocking assignments keep every register sampling
    // the pre-edge values regardless of statement order.
    if (!rn) begin
      y    <= '0;
      wrap <= 1'b0;
    end else begin
      y    <= y_nxt;
      wrap <= wrap_clr ? 1'b0 : (wrap | wrap_evt);
    end
  end

  // Terminal count is suppressed while reset is held.
  assign tc = rn & tc_raw;

endmodule
